// File: rtl/mem_scan_reader_if.sv
// Memory second read port plus the outgoing byte stream of mem_scan_reader.
interface mem_scan_reader_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [ADDR_W-1:0] address2;
  logic [7:0]        q;
  logic [7:0]        pixel;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              sof;
  logic              eof;

  // Reader side: drives the read address and the stream.
  modport master (
    output address2, pixel, pixel_valid, sof, eof,
    input  q, pixel_ready
  );

  // Memory/sink side.
  modport slave (
    input  address2, pixel, pixel_valid, sof, eof,
    output q, pixel_ready
  );
endinterface

// File: rtl/mem_scan_reader.sv
// Scans a frame of memory through a 1-cycle read port and streams it out
// through a shift-register skid FIFO with sof/eof tags.
module mem_scan_reader #(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       FRAME_SIZE = 64,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              done,
  mem_scan_reader_if.master bus
);

  localparam int unsigned IDX_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [ADDR_W-1:0] addr_q;
  logic              in_flight_q;
  logic              fl_sof_q, fl_eof_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        data_q [FIFO_DEPTH];
  logic [7:0]        data_d [FIFO_DEPTH];
  logic              tsof_q [FIFO_DEPTH];
  logic              tsof_d [FIFO_DEPTH];
  logic              teof_q [FIFO_DEPTH];
  logic              teof_d [FIFO_DEPTH];
  logic              valid_q, done_q, busy_q;

  logic              issue_c, last_c, pop_c, push_c, drain_done_c;
  logic [PTR_W-1:0]  wr_idx_c;

  assign last_c       = (index_q == LAST_IDX);
  assign pop_c        = (count_q != '0) && bus.pixel_ready;
  assign push_c       = in_flight_q;
  // Final eof leaves the FIFO with nothing behind it: frame is complete.
  assign drain_done_c = (state_q == S_DRAIN) && pop_c && teof_q[0] &&
                        (count_q == CNT_W'(1)) && !in_flight_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (issue_c && last_c && !continuous) state_d = S_DRAIN;
      S_DRAIN: if (drain_done_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Issue decision and next scan index; issue never oversubscribes the FIFO.
  always_comb begin
    issue_c = 1'b0;
    index_d = index_q;
    if (state_q == S_ISSUE &&
        ({1'b0, count_q} + (CNT_W + 1)'(in_flight_q)) < (CNT_W + 1)'(FIFO_DEPTH)) begin
      issue_c = 1'b1;
      index_d = last_c ? '0 : index_q + IDX_W'(1);
    end else if (state_q == S_IDLE) begin
      index_d = '0;
    end
  end

  // Shift-register FIFO: head is always entry 0, slots past count stay zero.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      data_d[i] = data_q[i];
      tsof_d[i] = tsof_q[i];
      teof_d[i] = teof_q[i];
    end
    if (pop_c) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        data_d[i] = data_q[i + 1];
        tsof_d[i] = tsof_q[i + 1];
        teof_d[i] = teof_q[i + 1];
      end
      data_d[FIFO_DEPTH-1] = '0;
      tsof_d[FIFO_DEPTH-1] = 1'b0;
      teof_d[FIFO_DEPTH-1] = 1'b0;
    end
    wr_idx_c = PTR_W'(count_q - CNT_W'(pop_c));
    if (push_c) begin
      data_d[wr_idx_c] = bus.q;
      tsof_d[wr_idx_c] = fl_sof_q;
      teof_d[wr_idx_c] = fl_eof_q;
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Datapath registers: scan index, read address, in-flight slot, FIFO, flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q     <= '0;
      addr_q      <= BASE_ADDR;
      in_flight_q <= 1'b0;
      fl_sof_q    <= 1'b0;
      fl_eof_q    <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        tsof_q[i] <= 1'b0;
        teof_q[i] <= 1'b0;
      end
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      index_q     <= index_d;
      addr_q      <= BASE_ADDR + ADDR_W'(index_d);
      in_flight_q <= issue_c;
      fl_sof_q    <= issue_c && (index_q == '0);
      fl_eof_q    <= issue_c && last_c;
      count_q     <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= data_d[i];
        tsof_q[i] <= tsof_d[i];
        teof_q[i] <= teof_d[i];
      end
      valid_q     <= (count_d != '0);
      done_q      <= pop_c && teof_q[0];
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.address2    = addr_q;
  assign bus.pixel       = data_q[0];
  assign bus.sof         = tsof_q[0];
  assign bus.eof         = teof_q[0];
  assign bus.pixel_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: doc/mem_scan_reader.md
Name: mem_scan_reader

Overview:
- Read-side client of the data memory's second read port (`address2` → `q`, 8-bit, synchronous).
- Sequentially scans a rectangular region of memory written by the memory stage and streams the bytes out with a valid/ready handshake.
- Intended consumers: display or debug output logic.
- Hides the memory read latency behind a small skid FIFO, so the stream runs at one byte per cycle when the sink is always ready.

Parameters:
- ADDR_W, 24, width of `address2` and of the base address.
- BASE_ADDR, 0, first memory address scanned.
- FRAME_SIZE, 64, bytes per frame (≥ 2).
- FIFO_DEPTH, 4, skid FIFO entries (power of two, ≥ 2).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a frame when idle.
- continuous  in  1  when 1, a new frame starts automatically after the last byte is issued.
- q  in  8  memory read data; holds mem[address2 of previous cycle].
- address2  out  ADDR_W  registered read address to memory.
- pixel  out  8  stream data (FIFO head).
- pixel_valid  out  1  `pixel` is valid.
- pixel_ready  in  1  sink accepts `pixel` this cycle.
- sof  out  1  qualifies `pixel`: first byte of frame.
- eof  out  1  qualifies `pixel`: last byte of frame.
- busy  out  1  frame in progress (issuing or draining).
- done  out  1  one-cycle pulse after the eof byte is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; `address2` = BASE_ADDR; index, FIFO pointers/count and the in-flight flag all cleared.
  - Outputs: `pixel_valid`=0, `sof`=0, `eof`=0, `busy`=0, `done`=0, `pixel`=0.
  - A reset mid-frame discards all in-flight and buffered data; a later `start` begins again at BASE_ADDR.
- Read timing:
  - An issue in cycle t drives `address2`=A from the register updated at the posedge opening cycle t.
  - `q`=mem[A] is valid in cycle t+1 and is written into the FIFO at the posedge ending cycle t+1, along with sof/eof tags computed at issue time.
  - Read latency is exactly 1 cycle, with one in-flight slot.
- Issue condition: state = ISSUE and (fifo_count + in_flight) < FIFO_DEPTH. This guarantees the FIFO never overflows.
- Index: 0..FRAME_SIZE-1; address = BASE_ADDR + index, computed modulo 2^ADDR_W (wraps if the region crosses the top of the address space).
- FSM:
  - IDLE: `start`=1 → ISSUE with index=0.
  - ISSUE: on each issue, index+1. When index = FRAME_SIZE-1 is issued:
    - continuous=1 → stay in ISSUE, index=0 (next frame follows back-to-back, no bubble);
    - continuous=0 → DRAIN.
  - DRAIN: no issues. When the FIFO is empty, nothing is in flight, and the eof byte has been accepted → IDLE.
- `done` pulses in the cycle after the eof handshake, in both modes. In continuous mode `busy` stays 1.
- `start` while `busy`=1 is ignored. Deasserting `continuous` mid-frame finishes the current frame, then goes to DRAIN.
- Stream:
  - `pixel_valid` = (fifo_count ≠ 0).
  - A handshake (valid & ready) pops the head at the posedge.
  - `pixel`/`sof`/`eof` stay stable while valid & !ready.
  - A simultaneous push and pop leaves the count unchanged.
- `busy` = (state ≠ IDLE).
- Throughput: with `pixel_ready` held at 1, the first `pixel_valid` appears 2 cycles after `start` is sampled, and FRAME_SIZE bytes follow on consecutive cycles.

Test Plan:
1. Preload mem[0..63]=i+1, BASE_ADDR=0, ready=1, pulse start → 64 consecutive valid cycles carrying 1..64; sof on byte 1, eof on byte 64; done pulses one cycle after; busy falls at the same time as the done pulse.
2. Same preload, ready toggling 1/0 each cycle → byte order still 1..64; `pixel` held stable during every stall; `address2` never runs more than FIFO_DEPTH ahead of the accepted bytes.
3. ready=0 for 20 cycles after start → exactly FIFO_DEPTH (4) issues, then `address2` frozen at 4; releasing ready drains 1..4 and resumes at 5.
4. continuous=1, two frames, ready=1 → byte 64 (eof) is followed immediately by byte 1 (sof); done pulses after each eof; busy stays 1.
5. Drive rst=0 at byte 30 of a frame → all outputs go to 0 immediately, `address2`=BASE_ADDR; a new start yields byte 1 first, with sof.
6. BASE_ADDR=24'hFFFFFE, FRAME_SIZE=4 → `address2` sequence FFFFFE, FFFFFF, 000000, 000001; start pulsed while busy has no effect.
